regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Owns the single write port of the 32x32 register file and shares it between
//   NUM_REQ writeback requesters (ALU, load unit, etc.) using valid/ready handshakes.
//   After reset, and on a Clear request, it runs a zero-fill sequence over r1..r31.
//   It then arbitrates round-robin and drives RegWrite/WriteRegister/WriteData from
//   registers, one cycle after acceptance.
// PARAMETERS
//   NUM_REQ  4   number of requesters (2..8)
//   DATA_W   32  write data width
//   ADDR_W   5   register address width (2**ADDR_W registers; r0 hardwired zero)
// PORTS
//   Clk            in   1                  clock, rising edge
//   Reset_n        in   1                  asynchronous reset, active low
//   Clear          in   1                  pulse: re-run zero-fill sequence
//   ReqValid       in   NUM_REQ            request i valid
//   ReqAddr        in   NUM_REQ*ADDR_W     request i address at [i*ADDR_W +: ADDR_W]
//   ReqData        in   NUM_REQ*DATA_W     request i data at [i*DATA_W +: DATA_W]
//   ReqReady       out  NUM_REQ            request i accepted this cycle (one-hot or zero)
//   RegWrite       out  1                  register file write enable (registered)
//   WriteRegister  out  ADDR_W             register file write address (registered)
//   WriteData      out  DATA_W             register file write data (registered)
//   Busy           out  1                  high while zero-fill sequence runs
// BEHAVIOUR
// - Reset (Reset_n low, takes effect immediately): RegWrite=0, WriteRegister=0,
//   WriteData=0, ReqReady=0, Busy=1, rr pointer=0, ClrCnt=1, state=CLEAR.
// - FSM has two states: CLEAR and RUN.
// - CLEAR: ReqReady=0 and Busy=1. Each cycle drives RegWrite=1, WriteRegister=ClrCnt,
//   WriteData=0 on the next edge, then increments ClrCnt.
//   - After the write of address 2**ADDR_W-1: go to RUN and set ClrCnt=1.
//   - The sequence is 31 write cycles; Busy=0 from the first RUN cycle.
//   - Clear is ignored while in CLEAR.
// - RUN arbitration (combinational on ReqValid and pointer):
//   - Grant = first i with ReqValid[i], searching from pointer upward and wrapping
//     at NUM_REQ.
//   - ReqReady[i] = grant[i]. Transfer = ReqValid[i] & ReqReady[i].
//   - Requesters must not make ReqValid depend on ReqReady.
//   - Requesters must hold ReqValid/ReqAddr/ReqData stable until accepted (bench
//     asserts this).
// - Pointer: after a transfer, pointer = (granted index + 1) mod NUM_REQ; with no
//   transfer, unchanged.
// - Latency: a transfer in cycle N gives RegWrite=1, WriteRegister=ReqAddr,
//   WriteData=ReqData in cycle N+1.
//   - No transfer: RegWrite=0 next cycle; WriteRegister/WriteData hold last value.
//   - Back-to-back transfers allowed every cycle; throughput 1 write/cycle.
// - Address 0: the request is accepted (ReqReady=1) but discarded. RegWrite stays 0,
//   and WriteRegister/WriteData hold.
// - Clear in RUN: no grant that cycle (Clear wins over any ReqValid). Next state
//   CLEAR, ClrCnt=1. An output write already registered from cycle N-1 completes
//   normally.
// - Reset_n asserted mid-CLEAR or mid-RUN: all state returns to reset values;
//   zero-fill restarts at r1.
// - Widths: ClrCnt is ADDR_W bits; the pointer is ceil(log2(NUM_REQ)) bits with
//   explicit wrap; no truncation warnings allowed.
// CONFIGURATION
//   RF_ARB_FIXED_PRI_EN defined: fixed priority, lowest index with ReqValid wins.
//   The pointer register is removed. All other behaviour is unchanged.
//   Undefined (default): round-robin as above.
// TESTING
// 1 Release Reset_n -> 31 cycles RegWrite=1, WriteRegister=1..31, WriteData=0,
//   Busy=1; then Busy=0, RegWrite=0.
// 2 RUN, ReqValid=4'b0010, addr 5, data 32'hDEADBEEF -> ReqReady=4'b0010 same cycle;
//   next cycle RegWrite=1, WriteRegister=5, WriteData=32'hDEADBEEF.
// 3 RUN, ReqValid=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3 with RegWrite=1
//   every cycle (RF_ARB_FIXED_PRI_EN: grant 0 every cycle).
// 4 ReqValid[0]=1, addr 0, data 32'h1234 -> ReqReady[0]=1; next cycle RegWrite=0,
//   WriteRegister/WriteData unchanged.
// 5 Clear=1 with ReqValid[2]=1 -> ReqReady=0, Busy=1, 31 zero-fill writes; first
//   RUN cycle ReqReady=4'b0100.
// 6 Drop Reset_n while ClrCnt=10 -> RegWrite=0, Busy=1 immediately; after release,
//   zero-fill restarts at WriteRegister=1.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshakes plus the registered register-file write port
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
);
  logic                      Clear;
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ-1:0]        ReqReady;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddr;
  logic [NUM_REQ*DATA_W-1:0] ReqData;
  logic                      RegWrite;
  logic [ADDR_W-1:0]         WriteRegister;
  logic [DATA_W-1:0]         WriteData;
  logic                      Busy;
  modport master (output Clear, ReqValid, ReqAddr, ReqData,
                  input  ReqReady, RegWrite, WriteRegister, WriteData, Busy);
  modport slave  (input  Clear, ReqValid, ReqAddr, ReqData,
                  output ReqReady, RegWrite, WriteRegister, WriteData, Busy);
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-fills r1..r31, then shares the register-file write port
// round-robin; defining RF_ARB_FIXED_PRI_EN switches to fixed lowest-index priority.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input logic Clk,
  input logic Reset_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, nextState;
  logic [ADDR_W-1:0] clrCnt;
  logic [PTR_W-1:0] loIdx, grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic xfer, fillDone, doWrite;
`ifdef RF_ARB_FIXED_PRI_EN
  always_comb begin
    loIdx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (bus.ReqValid[i]) loIdx = PTR_W'(i);
  end
  assign grantIdx = loIdx;
`else
  logic [PTR_W-1:0] ptr, hiIdx;
  logic hiHit;
  // hiIdx: first valid at or above the pointer; loIdx: wrap-around fallback
  always_comb begin
    loIdx = '0;
    hiIdx = '0;
    hiHit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.ReqValid[i]) loIdx = PTR_W'(i);
      if (bus.ReqValid[i] && i >= int'(ptr)) begin
        hiIdx = PTR_W'(i);
        hiHit = 1'b1;
      end
    end
  end
  assign grantIdx = hiHit ? hiIdx : loIdx;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) ptr <= '0;
    else if (xfer) ptr <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
`endif
  assign grant    = |bus.ReqValid ? NUM_REQ'(1) << grantIdx : '0;
  assign selAddr  = bus.ReqAddr[grantIdx*ADDR_W +: ADDR_W];
  assign selData  = bus.ReqData[grantIdx*DATA_W +: DATA_W];
  assign fillDone = clrCnt == '1;
  assign doWrite  = xfer && selAddr != '0;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= CLEAR;
    else state <= nextState;
  always_comb nextState = state == CLEAR ? (fillDone ? RUN : CLEAR) : (bus.Clear ? CLEAR : RUN);
  // Clear blocks any grant in the cycle it is seen
  always_comb begin
    bus.ReqReady = (state == RUN && !bus.Clear) ? grant : '0;
    bus.Busy     = state == CLEAR;
    xfer         = |bus.ReqReady;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      clrCnt            <= ADDR_W'(1);
      bus.RegWrite      <= 1'b0;
      bus.WriteRegister <= '0;
      bus.WriteData     <= '0;
    end else if (state == CLEAR) begin
      bus.RegWrite      <= 1'b1;
      bus.WriteRegister <= clrCnt;
      bus.WriteData     <= '0;
      clrCnt            <= fillDone ? ADDR_W'(1) : clrCnt + 1'b1;
    end else begin
      bus.RegWrite <= doWrite;
      if (doWrite) begin
        bus.WriteRegister <= selAddr;
        bus.WriteData     <= selData;
      end
      if (bus.Clear) clrCnt <= ADDR_W'(1);
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random stimulus against a behavioural model
module tb_regfile_write_arbiter;
  localparam int N = 4, DW = 32, AW = 5;
  logic Clk = 1'b0, Reset_n = 1'b0;
  int tests = 0, fails = 0;
  regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus();
  regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));
  always #5 Clk = ~Clk;
  logic [N-1:0] v;
  logic [AW-1:0] a[N];
  logic [DW-1:0] d[N];
  logic clr;
  bit mClearing, mRW;
  int mCnt, mPtr, lastG;
  logic [AW-1:0] mWr;
  logic [DW-1:0] mWd;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.ReqAddr[i*AW +: AW] = a[i];
      bus.ReqData[i*DW +: DW] = d[i];
    end
    bus.ReqValid = v;
    bus.Clear = clr;
  endtask
  function automatic int pick();
    if (mClearing || clr) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef RF_ARB_FIXED_PRI_EN
      int i = k;
`else
      int i = (mPtr + k) % N;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction
  task automatic mreset();
    mClearing = 1; mCnt = 1; mPtr = 0; mRW = 0; mWr = '0; mWd = '0; lastG = -1;
  endtask
  task automatic chk_out();
    chk("RegWrite", bus.RegWrite, mRW);
    chk("WriteRegister", bus.WriteRegister, mWr);
    chk("WriteData", bus.WriteData, mWd);
    chk("Busy", bus.Busy, mClearing);
  endtask
  task automatic tick();
    int g;
    logic [N-1:0] er;
    drive();
    #1;
    g = pick();
    er = g < 0 ? '0 : N'(1) << g;
    chk("ReqReady", bus.ReqReady, er);
    @(posedge Clk);
    if (mClearing) begin
      mRW = 1; mWr = AW'(mCnt); mWd = '0;
      if (mCnt == (1 << AW) - 1) begin mClearing = 0; mCnt = 1; end
      else mCnt++;
    end else if (clr) begin
      mClearing = 1; mCnt = 1; mRW = 0;
    end else if (g >= 0) begin
      mPtr = (g + 1) % N;
      mRW = a[g] != '0;
      if (mRW) begin mWr = a[g]; mWd = d[g]; end
    end else mRW = 0;
    lastG = g;
    #1;
    chk_out();
  endtask
  task automatic gen();
    for (int i = 0; i < N; i++) begin
      if (lastG == i) v[i] = 1'b0;
      if (!v[i] && $urandom_range(0, 1) == 1) begin
        v[i] = 1'b1;
        a[i] = AW'($urandom);
        d[i] = $urandom;
      end
    end
  endtask
  initial begin
    int exp3;
    clr = 0; v = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    drive();
    mreset();
    #3;
    chk_out();
    chk("reset_ready", bus.ReqReady, 0);
    @(posedge Clk); #1; Reset_n = 1'b1;
    repeat (31) tick();
    chk("fill_last", bus.WriteRegister, 31);
    tick();
    chk("run_busy", bus.Busy, 0);
    chk("run_idle", bus.RegWrite, 0);
    for (int i = 0; i < N; i++) begin a[i] = AW'(i + 8); d[i] = DW'(i + 32'h100); end
    v = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef RF_ARB_FIXED_PRI_EN
      exp3 = 8;
`else
      exp3 = k % 4 + 8;
`endif
      chk("rr_order", bus.WriteRegister, exp3);
      chk("rr_write", bus.RegWrite, 1);
    end
    v = 4'b0010; a[1] = 5; d[1] = 32'hDEADBEEF;
    tick();
    chk("single_wr", bus.WriteRegister, 5);
    chk("single_wd", bus.WriteData, 32'hDEADBEEF);
    v = 4'b0001; a[0] = 0; d[0] = 32'h1234;
    tick();
    chk("r0_nowrite", bus.RegWrite, 0);
    chk("r0_hold", bus.WriteData, 32'hDEADBEEF);
    v = 4'b0100; a[2] = 7; d[2] = 32'h77; clr = 1;
    tick();
    clr = 0;
    repeat (10) tick();
    clr = 1;
    tick();
    clr = 0;
    repeat (20) tick();
    tick();
    chk("post_clear_wr", bus.WriteRegister, 7);
    v = '0; clr = 1;
    tick();
    clr = 0;
    repeat (9) tick();
    Reset_n = 1'b0;
    #1;
    mreset();
    chk_out();
    @(posedge Clk); #1; Reset_n = 1'b1;
    tick();
    chk("restart_r1", bus.WriteRegister, 1);
    repeat (30) tick();
    repeat (500) begin
      gen();
      clr = $urandom_range(0, 39) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
